// File: rtl/msk_hpc2_rnd_feeder.sv
// Randomness feeder for masked HPC2 AND gadgets.
// Packs narrow PRNG beats into fresh R-bit words (R = d*(d-1)/2), buffers them
// in a small FIFO and presents the head word to the gadget. Every bit is used at
// most once; surplus bits of a word's last beat are dropped, never carried over.
module msk_hpc2_rnd_feeder #(
    parameter int unsigned d     = 2,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned R    = d * (d - 1) / 2,
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  prng_data,
    input  logic          prng_valid,
    output logic          prng_ready,
    input  logic          rnd_req,
    output logic [R-1:0]  rnd,
    output logic          rnd_valid,
    output logic [LW-1:0] level,
    output logic          underflow
);

    localparam int unsigned BPW = (R + W - 1) / W;
    localparam int unsigned BW  = BPW * W;
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned PW  = $clog2(DEPTH);

    logic [R-1:0]  asm_q;
    logic [CW-1:0] beat_q;
    logic [R-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;

    logic          accept;
    logic          last_beat;
    logic          push;
    logic          pop;
    logic [BW-1:0] asm_d;
    logic [R-1:0]  word;
    logic [PW-1:0] wptr_n;
    logic [PW-1:0] rptr_n;
    logic [LW-1:0] count_n;
    logic [R-1:0]  head_n;

    // Next-state: beat packing, FIFO pointer/count update and next head word.
    always_comb begin
        accept    = prng_valid & prng_ready;
        last_beat = (beat_q == CW'(BPW - 1));
        asm_d     = BW'(asm_q);
        for (int k = 0; k < int'(BPW); k++) begin
            if (beat_q == CW'(k)) begin
                asm_d[k*W +: W] = prng_data;
            end
        end
        word    = asm_d[R-1:0];
        push    = accept & last_beat;
        pop     = rnd_req & rnd_valid;
        wptr_n  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_n  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_n = level + LW'(push) - LW'(pop);
        head_n  = '0;
        if (count_n != '0) begin
            if (push && (wptr_q == rptr_n)) begin
                head_n = word;
            end else begin
                head_n = mem[rptr_n];
            end
        end
    end

    // Word storage; contents beyond the live count are never exposed, so no reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wptr_q] <= word;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            beat_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level      <= '0;
            prng_ready <= 1'b1;
            rnd_valid  <= 1'b0;
            rnd        <= '0;
            underflow  <= 1'b0;
        end else begin
            if (accept) begin
                asm_q  <= last_beat ? '0 : asm_d[R-1:0];
                beat_q <= last_beat ? '0 : beat_q + CW'(1);
            end
            wptr_q     <= wptr_n;
            rptr_q     <= rptr_n;
            level      <= count_n;
            prng_ready <= (count_n < LW'(DEPTH));
            rnd_valid  <= (count_n != '0);
            rnd        <= head_n;
            underflow  <= underflow | (rnd_req & ~rnd_valid);
        end
    end

endmodule

// File: tb/tb_msk_hpc2_rnd_feeder.sv
// Bench for msk_hpc2_rnd_feeder: directed packing checks on two small
// configurations, then directed and random traffic on a d=4/W=4 instance
// compared against a queue-based reference model.
module tb_msk_hpc2_rnd_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance 1: d=2 (R=1), W=8
    logic [7:0] d1;
    logic       v1, r1, q1, rv1, uf1;
    logic [0:0] rnd1;
    logic [2:0] lv1;
    msk_hpc2_rnd_feeder #(.d(2), .W(8), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .prng_data(d1), .prng_valid(v1), .prng_ready(r1),
        .rnd_req(q1), .rnd(rnd1), .rnd_valid(rv1), .level(lv1), .underflow(uf1));

    // Instance 2: d=3 (R=3), W=2
    logic [1:0] d2;
    logic       v2, r2, q2, rv2, uf2;
    logic [2:0] rnd2;
    logic [2:0] lv2;
    msk_hpc2_rnd_feeder #(.d(3), .W(2), .DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .prng_data(d2), .prng_valid(v2), .prng_ready(r2),
        .rnd_req(q2), .rnd(rnd2), .rnd_valid(rv2), .level(lv2), .underflow(uf2));

    // Instance 3: d=4 (R=6), W=4, two beats per word
    logic [3:0] d3;
    logic       v3, r3, q3, rv3, uf3;
    logic [5:0] rnd3;
    logic [2:0] lv3;
    msk_hpc2_rnd_feeder #(.d(4), .W(4), .DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .prng_data(d3), .prng_valid(v3), .prng_ready(r3),
        .rnd_req(q3), .rnd(rnd3), .rnd_valid(rv3), .level(lv3), .underflow(uf3));

    // Reference model for instance 3: word queue, pending beats, sticky flag.
    int mq[$];
    int mp[$];
    bit mu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance 3, model update from pre-edge state, then full compare.
    task automatic step3(input string tag, input logic v, input logic [3:0] dat,
                         input logic req, input logic r);
        bit acc, pp;
        int w;
        v3 = v; d3 = dat; q3 = req; rst = r;
        @(posedge clk);
        if (r) begin
            mq.delete(); mp.delete(); mu = 1'b0;
        end else begin
            acc = v && (mq.size() < 4);
            pp  = req && (mq.size() > 0);
            if (req && mq.size() == 0) mu = 1'b1;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mp.push_back(int'(dat));
                if (mp.size() == 2) begin
                    w = 0;
                    for (int k = 0; k < 2; k++) w += mp[k] << (4 * k);
                    mq.push_back(w % 64);
                    mp.delete();
                end
            end
        end
        #1;
        chk({tag, "_level"}, 32'(lv3), 32'(mq.size()));
        chk({tag, "_valid"}, 32'(rv3), 32'(mq.size() > 0));
        chk({tag, "_ready"}, 32'(r3), 32'(mq.size() < 4));
        chk({tag, "_rnd"}, 32'(rnd3), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        chk({tag, "_uf"}, 32'(uf3), 32'(mu));
        v3 = 1'b0; q3 = 1'b0; rst = 1'b0;
    endtask

    initial begin
        v1 = 0; q1 = 0; d1 = '0;
        v2 = 0; q2 = 0; d2 = '0;
        v3 = 0; q3 = 0; d3 = '0;
        mu = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(r1), 32'h1);
        chk("rst_valid", 32'(rv1), 32'h0);
        chk("rst_level", 32'(lv1), 32'h0);
        chk("rst_rnd", 32'(rnd1), 32'h0);
        chk("rst_uf", 32'(uf1), 32'h0);

        // R=1, W=8: one beat per word, bit 0 only
        v1 = 1; d1 = 8'hA5; tick();
        d1 = 8'h3C; tick();
        v1 = 0;
        chk("t1_level", 32'(lv1), 32'h2);
        chk("t1_rnd", 32'(rnd1), 32'h1);
        q1 = 1; tick(); q1 = 0;
        chk("t1_pop_rnd", 32'(rnd1), 32'h0);
        chk("t1_pop_level", 32'(lv1), 32'h1);
        q1 = 1; tick(); q1 = 0;
        chk("t1_empty_valid", 32'(rv1), 32'h0);

        // R=3, W=2: two beats per word, surplus top bit dropped
        v2 = 1; d2 = 2'b10; tick();
        chk("t2_partial_level", 32'(lv2), 32'h0);
        d2 = 2'b11; tick();
        chk("t2_w0_rnd", 32'(rnd2), 32'h6);
        d2 = 2'b01; tick();
        d2 = 2'b00; tick();
        v2 = 0;
        chk("t2_level", 32'(lv2), 32'h2);
        q2 = 1; tick(); q2 = 0;
        chk("t2_w1_rnd", 32'(rnd2), 32'h1);

        // Instance 3 from a fresh reset
        step3("t3_rst", 0, 4'h0, 0, 1);
        // Fill: four words, no requests
        for (int i = 0; i < 8; i++) step3("t3_fill", 1, 4'($urandom), 0, 0);
        chk("t3_full_level", 32'(lv3), 32'h4);
        chk("t3_full_ready", 32'(r3), 32'h0);
        // Beat offered while full together with a pop: pop only, beat not taken
        step3("t3_full_pop", 1, 4'hF, 1, 0);
        chk("t3_after_pop_level", 32'(lv3), 32'h3);
        chk("t3_after_pop_ready", 32'(r3), 32'h1);

        // Drain to one word, then complete a word on a popping edge
        step3("t4_pop", 0, 4'h0, 1, 0);
        step3("t4_pop", 0, 4'h0, 1, 0);
        step3("t4_b0", 1, 4'h5, 0, 0);
        step3("t4_b1", 1, 4'hA, 1, 0);
        chk("t4_level", 32'(lv3), 32'h1);
        chk("t4_rnd", 32'(rnd3), 32'h25);

        // Underflow: sticky across a refill, cleared only by reset
        step3("t5_pop", 0, 4'h0, 1, 0);
        step3("t5_under", 0, 4'h0, 1, 0);
        chk("t5_uf", 32'(uf3), 32'h1);
        chk("t5_rnd", 32'(rnd3), 32'h0);
        step3("t5_refill", 1, 4'h1, 0, 0);
        step3("t5_refill", 1, 4'h2, 0, 0);
        chk("t5_uf_held", 32'(uf3), 32'h1);
        step3("t5_rst", 0, 4'h0, 0, 1);
        chk("t5_uf_clear", 32'(uf3), 32'h0);

        // Reset drops a partial word
        step3("t6_b0", 1, 4'h3, 0, 0);
        step3("t6_rst", 0, 4'h0, 0, 1);
        step3("t6_b0", 1, 4'h9, 0, 0);
        step3("t6_b1", 1, 4'h6, 0, 0);
        chk("t6_rnd", 32'(rnd3), 32'h29);

        // Random traffic including occasional idle gaps and resets
        for (int i = 0; i < 600; i++) begin
            step3("rnd", ($urandom_range(0, 9) < 6), 4'($urandom),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
